mc_control_fsm: RTL and testbench
=================================

Name: mc_control_fsm

Overview:
Multi-cycle control sequencer for the MIPS datapath. It decodes the latched opcode/func fields and steps the shared ALU, memory port and register file through fetch, decode, execute, memory and writeback phases. It adds memory-ready and multiplier-done handshakes, and keeps a retired-instruction counter. It replaces single-cycle control where memory or the multiplier needs more than one cycle.

Parameters:
CNT_W, 32, width of retired-instruction counter
ALUOP_W, 3, width of ALUOp

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, synchronous, active-high
opcode  in  6  IR[31:26]
func  in  6  IR[5:0]
Zero  in  1  ALU zero flag (beq)
MemReady  in  1  memory completes current access this cycle
MultDone  in  1  multiplier finished
MemReq  out  1  memory access request
IorD  out  1  0=PC address, 1=ALUOut address
MemWrite  out  1  store strobe
IRWrite  out  1  latch instruction register
PCWrite  out  1  update PC
PCSrc  out  2  00=ALU result, 01=ALUOut (branch), 10=jump target
ALUSrcA  out  1  0=PC, 1=rs
ALUSrcB  out  2  00=rt, 01=const 4, 10=ext imm, 11=sext imm<<2
ZeroExt  out  1  1=zero-extend imm (andi/ori)
ALUOp  out  ALUOP_W  000 ADD, 001 SUB, 010 AND, 011 OR, 111 FUNCT
RegDst  out  1  1=rd, 0=rt
MemtoReg  out  1  1=MDR, 0=ALUOut
RegWrite  out  1  register file write
MultStart  out  1  one-cycle multiplier start
Retire  out  1  one-cycle pulse per completed instruction
Illegal  out  1  trap indicator (see Optional Feature)
InstrCount  out  CNT_W  retired count
State  out  4  current state, debug

Behaviour:
- Moore outputs decode the registered state. Exceptions: PCWrite in BRANCH, MultStart in DECODE, and handshake-gated strobes.
- While rst=1, all outputs are forced to 0. On the next clock edge: State=FETCH, InstrCount=0, Illegal=0.
- Reset mid-operation: the instruction is abandoned, no Retire is issued, and no write strobes are asserted.
- Unlisted outputs are 0 in each state.
- State encodings: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, EXEC_R 6, WB_R 7, BRANCH 8, JUMP 9, EXEC_I 10, WB_I 11, MULT 12, TRAP 13.
- FETCH: MemReq=1, IorD=0, ALUSrcB=01, ALUOp=ADD.
  - MemReady=0: hold in FETCH.
  - MemReady=1: IRWrite=1, PCWrite=1, PCSrc=00, go to DECODE.
- DECODE: ALUSrcB=11, ALUOp=ADD (branch target into ALUOut). Next state:
  - lw(35)/sw(43) -> MEM_ADDR
  - R-type func 32/33/36/37 -> EXEC_R
  - R-type func 24 -> MULT, with MultStart=1 this cycle
  - beq(4) -> BRANCH
  - j(2) -> JUMP
  - addi(8)/addiu(9)/andi(12)/ori(13) -> EXEC_I
  - anything else: illegal
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ADD. Go to MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: MemReq=1, IorD=1. Hold until MemReady, then MEM_WB.
- MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0. Retire, go to FETCH.
- MEM_WR: MemReq=1, IorD=1, MemWrite=1. Hold until MemReady, then Retire and go to FETCH.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=FUNCT. Go to WB_R.
- WB_R: RegWrite=1, RegDst=1. Retire, go to FETCH.
- MULT: wait for MultDone. Then Retire, go to FETCH.
  - MultDone is sampled only in MULT; it is ignored in every other state.
- BRANCH: ALUSrcA=1, ALUSrcB=00, SUB, PCSrc=01, PCWrite=Zero. Retire, go to FETCH.
- JUMP: PCSrc=10, PCWrite=1. Retire, go to FETCH.
- EXEC_I: ALUSrcA=1, ALUSrcB=10. ZeroExt=1 for andi/ori. ALUOp is ADD for 8/9, AND for 12, OR for 13. Go to WB_I.
- WB_I: RegWrite=1, RegDst=0, MemtoReg=0. Retire, go to FETCH.
- MemReady is ignored when MemReq=0.
- Retire and the InstrCount increment occur in the same cycle. InstrCount wraps from all-ones to 0.
- Latencies with zero wait: R/I-type 4 cycles, lw 5, sw 4, beq/j 3, mult 3+wait.

Optional Feature:
CTRL_ILLEGAL_TRAP_EN
- Defined: an illegal decode goes to TRAP. TRAP holds Illegal=1 with all other outputs 0, issues no MemReq, and exits only via rst.
- Undefined: an illegal decode returns to FETCH with no Retire and no count, acting as a silent NOP. The Illegal port exists but is tied to 0. The TRAP state is never reached.

Decomposition:
- Package mc_ctrl_pkg holds:
  - opcode constants (0, 2, 4, 8, 9, 12, 13, 35, 43)
  - func constants (24, 32, 33, 36, 37)
  - ALUOp encodings
  - ALUSrcB and PCSrc encodings
  - state encodings
- Sub-module mc_instr_decode: combinational opcode/func -> instruction class plus illegal flag. It is used by the DECODE next-state logic.

Test Plan:
- rst, then addi (8) with MemReady=1 -> states 0,1,10,11. In WB_I: RegWrite=1, RegDst=0. Retire once; InstrCount=1.
- add (op0/func32) with MemReady low for 3 FETCH cycles -> FETCH lasts 4 cycles, IRWrite only in the last. WB_R has RegDst=1. 7 cycles total.
- lw (35), MemReady 2 cycles late in MEM_RD -> MEM_WB has MemtoReg=1, RegWrite=1.
- sw (43) -> MemWrite=1 in MEM_WR, RegWrite never 1.
- beq (4): Zero=1 -> PCWrite=1, PCSrc=01. Zero=0 -> PCWrite=0. Both cases Retire.
- mult (func 24) -> MultStart is a 1-cycle pulse in DECODE. A stray MultDone during FETCH is ignored. MultDone 5 cycles later -> Retire. j (2) -> PCSrc=10.
- Opcode 63: with macro -> TRAP, Illegal=1, MemReq=0 until rst. Without macro -> back to FETCH, InstrCount unchanged.
- rst during MEM_RD -> next State=0, InstrCount=0, no Retire.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared constants and types for the multi-cycle MIPS control sequencer:
// opcode/func values, ALU and mux select encodings, state and class enums.
package mc_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_ADDIU = 6'd9;
  localparam logic [5:0] OP_ANDI  = 6'd12;
  localparam logic [5:0] OP_ORI   = 6'd13;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [5:0] FN_MULT  = 6'd24;
  localparam logic [5:0] FN_ADD   = 6'd32;
  localparam logic [5:0] FN_ADDU  = 6'd33;
  localparam logic [5:0] FN_AND   = 6'd36;
  localparam logic [5:0] FN_OR    = 6'd37;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_FUNCT = 3'b111;

  localparam logic [1:0] SRCB_RT    = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_BROFF = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_WB_R     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_EXEC_I   = 4'd10,
    S_WB_I     = 4'd11,
    S_MULT     = 4'd12,
    S_TRAP     = 4'd13
  } state_e;

  typedef enum logic [2:0] {
    CLS_MEM,
    CLS_R,
    CLS_MULT,
    CLS_BEQ,
    CLS_J,
    CLS_IMM,
    CLS_ILL
  } instr_cls_e;

endpackage

// File: rtl/mc_instr_decode.sv
// Combinational opcode/func classifier feeding the DECODE-state branch of the
// control sequencer; anything not recognised is flagged illegal.
module mc_instr_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0]  opcode_i,
  input  logic [5:0]  func_i,
  output instr_cls_e  cls_o,
  output logic        illegal_o
);

  always_comb begin
    cls_o = CLS_ILL;
    case (opcode_i)
      OP_LW, OP_SW: cls_o = CLS_MEM;
      OP_RTYPE: begin
        case (func_i)
          FN_ADD, FN_ADDU, FN_AND, FN_OR: cls_o = CLS_R;
          FN_MULT:                        cls_o = CLS_MULT;
          default:                        cls_o = CLS_ILL;
        endcase
      end
      OP_BEQ:                               cls_o = CLS_BEQ;
      OP_J:                                 cls_o = CLS_J;
      OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI:   cls_o = CLS_IMM;
      default:                              cls_o = CLS_ILL;
    endcase
  end

  assign illegal_o = (cls_o == CLS_ILL);

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS control sequencer with memory-ready / multiplier-done
// handshakes and a retired-instruction counter. CTRL_ILLEGAL_TRAP_EN enables the TRAP state.
module mc_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int ALUOP_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic [5:0]         func,
  input  logic               Zero,
  input  logic               MemReady,
  input  logic               MultDone,
  output logic               MemReq,
  output logic               IorD,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               PCWrite,
  output logic [1:0]         PCSrc,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic               ZeroExt,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               RegDst,
  output logic               MemtoReg,
  output logic               RegWrite,
  output logic               MultStart,
  output logic               Retire,
  output logic               Illegal,
  output logic [CNT_W-1:0]   InstrCount,
  output logic [3:0]         State
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  instr_cls_e       cls;
  logic             dec_illegal;
  logic             is_andor;

  logic       mem_req, iord, mem_write, ir_write, pc_write, src_a, zext;
  logic       reg_dst, mem_to_reg, reg_write, mult_start, retire, illegal;
  logic [1:0] pc_src, src_b;
  logic [2:0] alu_op;

  mc_instr_decode u_decode (
    .opcode_i  (opcode),
    .func_i    (func),
    .cls_o     (cls),
    .illegal_o (dec_illegal)
  );

  assign is_andor = (opcode == OP_ANDI) || (opcode == OP_ORI);

  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    iord       = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PCSRC_ALU;
    src_a      = 1'b0;
    src_b      = SRCB_RT;
    zext       = 1'b0;
    alu_op     = ALU_ADD;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    mult_start = 1'b0;
    retire     = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        src_b   = SRCB_FOUR;
        if (MemReady) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        // ALU precomputes the branch target here so BRANCH can use ALUOut.
        src_b = SRCB_BROFF;
        if (dec_illegal) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
          state_d = S_TRAP;
`else
          state_d = S_FETCH;
`endif
        end else begin
          case (cls)
            CLS_MEM:  state_d = S_MEM_ADDR;
            CLS_R:    state_d = S_EXEC_R;
            CLS_MULT: begin
              state_d    = S_MULT;
              mult_start = 1'b1;
            end
            CLS_BEQ:  state_d = S_BRANCH;
            CLS_J:    state_d = S_JUMP;
            CLS_IMM:  state_d = S_EXEC_I;
            default:  state_d = S_FETCH;
          endcase
        end
      end
      S_MEM_ADDR: begin
        src_a   = 1'b1;
        src_b   = SRCB_IMM;
        state_d = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (MemReady) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WR: begin
        mem_req   = 1'b1;
        iord      = 1'b1;
        mem_write = 1'b1;
        if (MemReady) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXEC_R: begin
        src_a   = 1'b1;
        alu_op  = ALU_FUNCT;
        state_d = S_WB_R;
      end
      S_WB_R: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_MULT: begin
        if (MultDone) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_BRANCH: begin
        src_a    = 1'b1;
        alu_op   = ALU_SUB;
        pc_src   = PCSRC_ALUOUT;
        pc_write = Zero;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_JUMP: begin
        pc_src   = PCSRC_JUMP;
        pc_write = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_EXEC_I: begin
        src_a   = 1'b1;
        src_b   = SRCB_IMM;
        zext    = is_andor;
        alu_op  = (opcode == OP_ANDI) ? ALU_AND :
                  (opcode == OP_ORI)  ? ALU_OR  : ALU_ADD;
        state_d = S_WB_I;
      end
      S_WB_I: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
`ifdef CTRL_ILLEGAL_TRAP_EN
      S_TRAP: illegal = 1'b1;
`endif
      default: state_d = S_FETCH;
    endcase
  end

  assign count_d = retire ? count_q + CNT_W'(1) : count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Reset masks every output so an abandoned instruction cannot strobe anything.
  assign MemReq     = mem_req    & ~rst;
  assign IorD       = iord       & ~rst;
  assign MemWrite   = mem_write  & ~rst;
  assign IRWrite    = ir_write   & ~rst;
  assign PCWrite    = pc_write   & ~rst;
  assign PCSrc      = rst ? 2'b00 : pc_src;
  assign ALUSrcA    = src_a      & ~rst;
  assign ALUSrcB    = rst ? 2'b00 : src_b;
  assign ZeroExt    = zext       & ~rst;
  assign ALUOp      = rst ? '0 : ALUOP_W'(alu_op);
  assign RegDst     = reg_dst    & ~rst;
  assign MemtoReg   = mem_to_reg & ~rst;
  assign RegWrite   = reg_write  & ~rst;
  assign MultStart  = mult_start & ~rst;
  assign Retire     = retire     & ~rst;
  assign Illegal    = illegal    & ~rst;
  assign InstrCount = rst ? '0 : count_q;
  assign State      = rst ? 4'd0 : state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: a phase-list model of each instruction drives
// handshakes and predicts per-cycle state, retire and strobe totals.
module tb_mc_control_fsm;

  localparam int CNT_W = 4;

  localparam int C_LW = 0, C_SW = 1, C_R = 2, C_MULT = 3, C_BEQ = 4;
  localparam int C_J = 5, C_IMM = 6, C_ILL = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [5:0] opcode = '0, func = '0;
  logic Zero = 1'b0, MemReady = 1'b0, MultDone = 1'b0;
  logic MemReq, IorD, MemWrite, IRWrite, PCWrite, ALUSrcA, ZeroExt;
  logic RegDst, MemtoReg, RegWrite, MultStart, Retire, Illegal;
  logic [1:0] PCSrc, ALUSrcB;
  logic [2:0] ALUOp;
  logic [CNT_W-1:0] InstrCount;
  logic [3:0] State;

  typedef struct packed {
    logic [3:0] st;
    logic mem_req, iord, mem_write, ir_write, pc_write;
    logic [1:0] pc_src;
    logic src_a;
    logic [1:0] src_b;
    logic zext;
    logic [2:0] alu_op;
    logic reg_dst, mem_to_reg, reg_write, mult_start, retire, illegal;
  } snap_t;

  snap_t snaps[$];
  logic [CNT_W-1:0] exp_q[$];
  logic [CNT_W-1:0] model_count;
  int checks = 0;
  int errors = 0;
  bit stray_done = 1'b0;

  mc_control_fsm #(.CNT_W(CNT_W), .ALUOP_W(3)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func(func), .Zero(Zero),
    .MemReady(MemReady), .MultDone(MultDone), .MemReq(MemReq), .IorD(IorD),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ZeroExt(ZeroExt), .ALUOp(ALUOp),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .MultStart(MultStart), .Retire(Retire), .Illegal(Illegal),
    .InstrCount(InstrCount), .State(State)
  );

  always #5 clk = ~clk;

  function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'd35) return C_LW;
    if (op == 6'd43) return C_SW;
    if (op == 6'd4)  return C_BEQ;
    if (op == 6'd2)  return C_J;
    if (op == 6'd8 || op == 6'd9 || op == 6'd12 || op == 6'd13) return C_IMM;
    if (op == 6'd0 && (fn == 6'd32 || fn == 6'd33 || fn == 6'd36 || fn == 6'd37)) return C_R;
    if (op == 6'd0 && fn == 6'd24) return C_MULT;
    return C_ILL;
  endfunction

  task automatic apply_reset(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      rst = 1'b1;
      MemReady = 1'($urandom_range(0, 1));
      MultDone = 1'($urandom_range(0, 1));
      Zero = 1'($urandom_range(0, 1));
      @(negedge clk);
      checks++;
      if ({MemReq, IorD, MemWrite, IRWrite, PCWrite, PCSrc, ALUSrcA, ALUSrcB, ZeroExt,
           ALUOp, RegDst, MemtoReg, RegWrite, MultStart, Retire, Illegal, InstrCount,
           State} !== '0) begin
        errors++;
        $display("FAIL rst_outputs_zero got State=%0d Retire=%b MemReq=%b RegWrite=%b MemWrite=%b want all 0",
                 State, Retire, MemReq, RegWrite, MemWrite);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    MemReady = 1'b0;
    MultDone = 1'b0;
    @(negedge clk);
    checks++;
    if (State !== 4'd0 || InstrCount !== '0 || Illegal !== 1'b0 || Retire !== 1'b0) begin
      errors++;
      $display("FAIL post_reset got State=%0d Count=%0d Illegal=%b Retire=%b want 0 0 0 0",
               State, InstrCount, Illegal, Retire);
    end
    exp_q.delete();
    model_count = '0;
  endtask

  // Runs one instruction; abort_at >= 0 stops after that many cycles (no totals).
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int fw, input int mw, input int mlw,
                           input int trap_n, input int abort_at);
    int es[$];
    int cls, last, n, mem_rdy_idx;
    int n_ir, n_rw, n_mw, n_pw, n_ms;
    int e_rw, e_mw, e_pw, e_ms;
    bit ret_exp, exp_memreq, exp_ret;
    logic [CNT_W-1:0] exp_cnt;
    snap_t s;
    cls = classify(op, fn);
    es = {};
    for (int k = 0; k <= fw; k++) es.push_back(0);
    es.push_back(1);
    case (cls)
      C_LW: begin
        es.push_back(2);
        for (int k = 0; k <= mw; k++) es.push_back(3);
        es.push_back(4);
      end
      C_SW: begin
        es.push_back(2);
        for (int k = 0; k <= mw; k++) es.push_back(5);
      end
      C_R:    begin es.push_back(6); es.push_back(7); end
      C_MULT: for (int k = 0; k <= mlw; k++) es.push_back(12);
      C_BEQ:  es.push_back(8);
      C_J:    es.push_back(9);
      C_IMM:  begin es.push_back(10); es.push_back(11); end
      default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
        for (int k = 0; k < trap_n; k++) es.push_back(13);
`endif
      end
    endcase
    ret_exp = (cls != C_ILL);
    last = es.size() - 1;
    mem_rdy_idx = fw + 3 + mw;
    n = (abort_at >= 0) ? abort_at : es.size();
    snaps.delete();
    n_ir = 0; n_rw = 0; n_mw = 0; n_pw = 0; n_ms = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      opcode = op; func = fn; Zero = z;
      if (i < fw) MemReady = 1'b0;
      else if (i == fw) MemReady = 1'b1;
      else if (es[i] == 3 || es[i] == 5) MemReady = (i == mem_rdy_idx);
      else MemReady = 1'($urandom_range(0, 1));
      if (es[i] == 12) MultDone = (i == last);
      else if (stray_done && es[i] == 0) MultDone = 1'b1;
      else MultDone = 1'($urandom_range(0, 1));
      @(negedge clk);
      s = '{State, MemReq, IorD, MemWrite, IRWrite, PCWrite, PCSrc, ALUSrcA, ALUSrcB,
            ZeroExt, ALUOp, RegDst, MemtoReg, RegWrite, MultStart, Retire, Illegal};
      snaps.push_back(s);
      if (i == 0 && exp_q.size() > 0) begin
        exp_cnt = exp_q.pop_front();
        checks++;
        if (InstrCount !== exp_cnt) begin
          errors++;
          $display("FAIL instr_count got %0d want %0d", InstrCount, exp_cnt);
        end
      end
      checks++;
      if (State !== 4'(es[i])) begin
        errors++;
        $display("FAIL state op=%0d cyc=%0d got %0d want %0d", op, i, State, es[i]);
      end
      exp_ret = ret_exp && (i == last);
      checks++;
      if (Retire !== exp_ret) begin
        errors++;
        $display("FAIL retire op=%0d cyc=%0d got %b want %b", op, i, Retire, exp_ret);
      end
      exp_memreq = (es[i] == 0 || es[i] == 3 || es[i] == 5);
      checks++;
      if (MemReq !== exp_memreq) begin
        errors++;
        $display("FAIL memreq op=%0d cyc=%0d got %b want %b", op, i, MemReq, exp_memreq);
      end
      checks++;
      if (Illegal !== (es[i] == 13)) begin
        errors++;
        $display("FAIL illegal op=%0d cyc=%0d got %b want %b", op, i, Illegal, es[i] == 13);
      end
      if (es[i] == 13) begin
        checks++;
        if ({s.mem_req, s.iord, s.mem_write, s.ir_write, s.pc_write, s.pc_src, s.src_a,
             s.src_b, s.zext, s.alu_op, s.reg_dst, s.mem_to_reg, s.reg_write,
             s.mult_start, s.retire} !== '0) begin
          errors++;
          $display("FAIL trap_quiet cyc=%0d got nonzero strobes want 0", i);
        end
      end
      n_ir += int'(IRWrite); n_rw += int'(RegWrite); n_mw += int'(MemWrite);
      n_pw += int'(PCWrite); n_ms += int'(MultStart);
    end
    if (abort_at < 0) begin
      e_rw = (cls == C_LW || cls == C_R || cls == C_IMM) ? 1 : 0;
      e_mw = (cls == C_SW) ? mw + 1 : 0;
      e_pw = 1 + ((cls == C_J) ? 1 : 0) + ((cls == C_BEQ && z) ? 1 : 0);
      e_ms = (cls == C_MULT) ? 1 : 0;
      checks++;
      if (n_ir !== 1 || snaps[fw].ir_write !== 1'b1) begin
        errors++;
        $display("FAIL irwrite op=%0d got %0d pulses (at fetch end %b) want 1", op, n_ir, snaps[fw].ir_write);
      end
      checks++;
      if (n_rw !== e_rw) begin
        errors++;
        $display("FAIL regwrite_count op=%0d got %0d want %0d", op, n_rw, e_rw);
      end
      checks++;
      if (n_mw !== e_mw) begin
        errors++;
        $display("FAIL memwrite_count op=%0d got %0d want %0d", op, n_mw, e_mw);
      end
      checks++;
      if (n_pw !== e_pw) begin
        errors++;
        $display("FAIL pcwrite_count op=%0d got %0d want %0d", op, n_pw, e_pw);
      end
      checks++;
      if (n_ms !== e_ms || (e_ms == 1 && snaps[fw + 1].mult_start !== 1'b1)) begin
        errors++;
        $display("FAIL multstart op=%0d got %0d pulses want %0d in DECODE", op, n_ms, e_ms);
      end
      if (ret_exp) model_count = model_count + 1'b1;
      exp_q.push_back(model_count);
    end
  endtask

  task automatic test_reset();
    apply_reset(3);
  endtask

  task automatic test_addi();
    run_instr(6'd8, 6'($urandom), 1'b0, 0, 0, 0, 0, -1);
    checks++;
    if (snaps[0].src_b !== 2'b01 || snaps[0].alu_op !== 3'b000 || snaps[0].iord !== 1'b0 ||
        snaps[0].pc_src !== 2'b00) begin
      errors++;
      $display("FAIL fetch_ctrl got srcb=%0d aluop=%0d iord=%b pcsrc=%0d want 1 0 0 0",
               snaps[0].src_b, snaps[0].alu_op, snaps[0].iord, snaps[0].pc_src);
    end
    checks++;
    if (snaps[1].src_b !== 2'b11 || snaps[1].alu_op !== 3'b000 || snaps[1].src_a !== 1'b0) begin
      errors++;
      $display("FAIL decode_ctrl got srcb=%0d aluop=%0d srca=%b want 3 0 0",
               snaps[1].src_b, snaps[1].alu_op, snaps[1].src_a);
    end
    checks++;
    if (snaps[2].src_a !== 1'b1 || snaps[2].src_b !== 2'b10 || snaps[2].alu_op !== 3'b000 ||
        snaps[2].zext !== 1'b0) begin
      errors++;
      $display("FAIL exec_i_addi got srca=%b srcb=%0d aluop=%0d zext=%b want 1 2 0 0",
               snaps[2].src_a, snaps[2].src_b, snaps[2].alu_op, snaps[2].zext);
    end
    checks++;
    if (snaps[3].reg_write !== 1'b1 || snaps[3].reg_dst !== 1'b0 || snaps[3].mem_to_reg !== 1'b0) begin
      errors++;
      $display("FAIL wb_i got rw=%b rd=%b m2r=%b want 1 0 0",
               snaps[3].reg_write, snaps[3].reg_dst, snaps[3].mem_to_reg);
    end
  endtask

  task automatic test_add();
    run_instr(6'd0, 6'd32, 1'b0, 3, 0, 0, 0, -1);
    checks++;
    if (snaps[5].src_a !== 1'b1 || snaps[5].src_b !== 2'b00 || snaps[5].alu_op !== 3'b111) begin
      errors++;
      $display("FAIL exec_r got srca=%b srcb=%0d aluop=%0d want 1 0 7",
               snaps[5].src_a, snaps[5].src_b, snaps[5].alu_op);
    end
    checks++;
    if (snaps[6].reg_dst !== 1'b1 || snaps[6].reg_write !== 1'b1) begin
      errors++;
      $display("FAIL wb_r got rd=%b rw=%b want 1 1", snaps[6].reg_dst, snaps[6].reg_write);
    end
  endtask

  task automatic test_lw();
    run_instr(6'd35, 6'($urandom), 1'b0, 0, 2, 0, 0, -1);
    checks++;
    if (snaps[2].src_a !== 1'b1 || snaps[2].src_b !== 2'b10 || snaps[2].alu_op !== 3'b000) begin
      errors++;
      $display("FAIL mem_addr got srca=%b srcb=%0d aluop=%0d want 1 2 0",
               snaps[2].src_a, snaps[2].src_b, snaps[2].alu_op);
    end
    checks++;
    if (snaps[3].iord !== 1'b1 || snaps[5].iord !== 1'b1) begin
      errors++;
      $display("FAIL mem_rd_iord got %b/%b want 1/1", snaps[3].iord, snaps[5].iord);
    end
    checks++;
    if (snaps[6].mem_to_reg !== 1'b1 || snaps[6].reg_write !== 1'b1 || snaps[6].reg_dst !== 1'b0) begin
      errors++;
      $display("FAIL mem_wb got m2r=%b rw=%b rd=%b want 1 1 0",
               snaps[6].mem_to_reg, snaps[6].reg_write, snaps[6].reg_dst);
    end
  endtask

  task automatic test_sw();
    run_instr(6'd43, 6'($urandom), 1'b0, 1, 1, 0, 0, -1);
    checks++;
    if (snaps[4].iord !== 1'b1 || snaps[4].mem_write !== 1'b1) begin
      errors++;
      $display("FAIL mem_wr got iord=%b mw=%b want 1 1", snaps[4].iord, snaps[4].mem_write);
    end
  endtask

  task automatic test_beq();
    run_instr(6'd4, 6'($urandom), 1'b1, 0, 0, 0, 0, -1);
    checks++;
    if (snaps[2].pc_write !== 1'b1 || snaps[2].pc_src !== 2'b01 || snaps[2].alu_op !== 3'b001 ||
        snaps[2].src_a !== 1'b1 || snaps[2].src_b !== 2'b00) begin
      errors++;
      $display("FAIL beq_taken got pcw=%b pcsrc=%0d aluop=%0d want 1 1 1",
               snaps[2].pc_write, snaps[2].pc_src, snaps[2].alu_op);
    end
    run_instr(6'd4, 6'($urandom), 1'b0, 0, 0, 0, 0, -1);
    checks++;
    if (snaps[2].pc_write !== 1'b0) begin
      errors++;
      $display("FAIL beq_not_taken got pcw=%b want 0", snaps[2].pc_write);
    end
  endtask

  task automatic test_mult_jump();
    stray_done = 1'b1;
    run_instr(6'd0, 6'd24, 1'b0, 2, 0, 5, 0, -1);
    stray_done = 1'b0;
    run_instr(6'd2, 6'($urandom), 1'b0, 0, 0, 0, 0, -1);
    checks++;
    if (snaps[2].pc_src !== 2'b10 || snaps[2].pc_write !== 1'b1) begin
      errors++;
      $display("FAIL jump got pcsrc=%0d pcw=%b want 2 1", snaps[2].pc_src, snaps[2].pc_write);
    end
  endtask

  task automatic test_illegal();
    run_instr(6'd63, 6'($urandom), 1'b0, 0, 0, 0, 6, -1);
`ifdef CTRL_ILLEGAL_TRAP_EN
    apply_reset(1);
`endif
    run_instr(6'd13, 6'($urandom), 1'b0, 0, 0, 0, 0, -1);
  endtask

  task automatic test_random();
    logic [5:0] op, fn;
    int k, maxk;
    logic [2:0] e_alu;
`ifdef CTRL_ILLEGAL_TRAP_EN
    maxk = 9;
`else
    maxk = 10;
`endif
    for (int it = 0; it < 30; it++) begin
      k = $urandom_range(0, maxk);
      fn = 6'($urandom);
      case (k)
        0: op = 6'd35;
        1: op = 6'd43;
        2: begin op = 6'd0; fn = 6'd32; end
        3: begin op = 6'd0; fn = 6'd33; end
        4: begin op = 6'd0; fn = 6'd36; end
        5: begin op = 6'd0; fn = 6'd37; end
        6: begin op = 6'd0; fn = 6'd24; end
        7: op = 6'd4;
        8: op = 6'd2;
        9: begin
          case ($urandom_range(0, 3))
            0: op = 6'd8;
            1: op = 6'd9;
            2: op = 6'd12;
            default: op = 6'd13;
          endcase
        end
        default: begin op = 6'd0; fn = 6'd25; end
      endcase
      run_instr(op, fn, 1'($urandom_range(0, 1)), $urandom_range(0, 2),
                $urandom_range(0, 3), $urandom_range(0, 4), 0, -1);
      if (classify(op, fn) == C_IMM) begin
        e_alu = (op == 6'd12) ? 3'b010 : (op == 6'd13) ? 3'b011 : 3'b000;
        checks++;
        if (snaps[snaps.size() - 2].alu_op !== e_alu ||
            snaps[snaps.size() - 2].zext !== (op == 6'd12 || op == 6'd13)) begin
          errors++;
          $display("FAIL exec_i_ctrl op=%0d got aluop=%0d zext=%b want %0d %b", op,
                   snaps[snaps.size() - 2].alu_op, snaps[snaps.size() - 2].zext, e_alu,
                   op == 6'd12 || op == 6'd13);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    run_instr(6'd35, 6'd0, 1'b0, 0, 4, 0, 0, 5);
    apply_reset(1);
    run_instr(6'd9, 6'd0, 1'b0, 0, 0, 0, 0, -1);
  endtask

  task automatic drain();
    logic [CNT_W-1:0] exp_cnt;
    @(posedge clk); #1;
    MemReady = 1'b0;
    @(negedge clk);
    while (exp_q.size() > 0) begin
      exp_cnt = exp_q.pop_front();
      checks++;
      if (InstrCount !== exp_cnt) begin
        errors++;
        $display("FAIL final_count got %0d want %0d", InstrCount, exp_cnt);
      end
    end
  endtask

  initial begin
    model_count = '0;
    test_reset();
    test_addi();
    test_add();
    test_lw();
    test_sw();
    test_beq();
    test_mult_jump();
    test_illegal();
    test_random();
    test_reset_mid();
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
